// File: rtl/cicero_job_loader.sv
// Streams one regex job (code words followed by the packed string) into a CICERO
// coprocessor through its register interface, starts it, waits for a verdict and
// reads back the elapsed-clock counter.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   job_*                    job descriptor handshake (code word count, string byte count)
//   word_*                   input word stream: code words, then string bytes packed LE
//   address_register,
//   data_in_register,
//   cmd_register             coprocessor write port and command
//   start/end_cc_pointer_*   string byte window handed to the coprocessor
//   status_register,
//   data_o_register          coprocessor status and read-back data
//   res_*                    result handshake: accepted, error, elapsed cycles
//   busy                     high whenever a job is in flight
module cicero_job_loader #(
  parameter int unsigned CC_ID_BITS = 2,
  parameter int unsigned REG_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 job_valid,
  output logic                 job_ready,
  input  logic [15:0]          job_code_words,
  input  logic [15:0]          job_string_bytes,
  input  logic                 word_valid,
  output logic                 word_ready,
  input  logic [31:0]          word_data,
  output logic [REG_WIDTH-1:0] address_register,
  output logic [REG_WIDTH-1:0] data_in_register,
  output logic [REG_WIDTH-1:0] cmd_register,
  output logic [REG_WIDTH-1:0] start_cc_pointer_register,
  output logic [REG_WIDTH-1:0] end_cc_pointer_register,
  input  logic [REG_WIDTH-1:0] status_register,
  input  logic [REG_WIDTH-1:0] data_o_register,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic                 res_accepted,
  output logic                 res_error,
  output logic [31:0]          res_cycles,
  output logic                 busy
);

  // Coprocessor command and status encodings.
  localparam logic [REG_WIDTH-1:0] CmdNop          = REG_WIDTH'(0);
  localparam logic [REG_WIDTH-1:0] CmdWrite        = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] CmdStart        = REG_WIDTH'(3);
  localparam logic [REG_WIDTH-1:0] CmdReadElapsed  = REG_WIDTH'(6);
  localparam logic [REG_WIDTH-1:0] StatusRunning   = REG_WIDTH'(1);
  localparam logic [REG_WIDTH-1:0] StatusAccepted  = REG_WIDTH'(2);
  localparam logic [REG_WIDTH-1:0] StatusRejected  = REG_WIDTH'(3);

  localparam logic [REG_WIDTH-1:0] AlignMask = REG_WIDTH'((64'd1 << CC_ID_BITS) - 64'd1);

  typedef enum logic [3:0] {
    StIdle, StWrSetup, StWrCmd, StWrNop, StStartSetup,
    StStartCmd, StWait, StElapCmd, StElapCap, StResult
  } state_e;

  state_e         state_q;
  logic [16:0]    code_words_q;   // one extra bit so it compares directly with word_idx_q
  logic [15:0]    str_bytes_q;
  logic [16:0]    word_idx_q;
  logic           start_hold_q;   // second cycle of the CMD_START pulse

  logic [16:0]          str_words;
  logic [16:0]          total_words;
  logic [REG_WIDTH-1:0] code_bytes;
  logic [REG_WIDTH-1:0] str_start;
  logic [REG_WIDTH-1:0] str_end;
  logic [REG_WIDTH-1:0] word_addr;

  always_comb begin
    str_words   = ({1'b0, str_bytes_q} + 17'd3) >> 2;
    total_words = code_words_q + str_words;
    code_bytes  = REG_WIDTH'({code_words_q, 2'b00});
    // Round the end of the code section up to the next aligned string start.
    str_start   = (code_bytes + AlignMask) & ~AlignMask;
    str_end     = str_start + REG_WIDTH'(str_bytes_q) - REG_WIDTH'(1);
    if (word_idx_q < code_words_q) begin
      word_addr = REG_WIDTH'(word_idx_q);
    end else begin
      word_addr = (str_start >> 2) + REG_WIDTH'(word_idx_q - code_words_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                   <= StIdle;
      code_words_q              <= '0;
      str_bytes_q               <= '0;
      word_idx_q                <= '0;
      start_hold_q              <= 1'b0;
      job_ready                 <= 1'b0;
      word_ready                <= 1'b0;
      busy                      <= 1'b0;
      address_register          <= '0;
      data_in_register          <= '0;
      cmd_register              <= CmdNop;
      start_cc_pointer_register <= '0;
      end_cc_pointer_register   <= '0;
      res_valid                 <= 1'b0;
      res_accepted              <= 1'b0;
      res_error                 <= 1'b0;
      res_cycles                <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            job_ready    <= 1'b0;
            busy         <= 1'b1;
            code_words_q <= {1'b0, job_code_words};
            str_bytes_q  <= job_string_bytes;
            word_idx_q   <= '0;
            res_accepted <= 1'b0;
            res_error    <= 1'b0;
            res_cycles   <= '0;
            if (job_string_bytes == 16'd0) begin
              res_error <= 1'b1;
              res_valid <= 1'b1;
              state_q   <= StResult;
            end else begin
              word_ready <= 1'b1;
              state_q    <= StWrSetup;
            end
          end
        end
        StWrSetup: begin
          if (word_valid) begin
            word_ready       <= 1'b0;
            address_register <= word_addr;
            data_in_register <= REG_WIDTH'(word_data);
            cmd_register     <= CmdWrite;
            state_q          <= StWrCmd;
          end
        end
        StWrCmd: begin
          cmd_register <= CmdNop;
          word_idx_q   <= word_idx_q + 17'd1;
          state_q      <= StWrNop;
        end
        StWrNop: begin
          if (word_idx_q == total_words) begin
            start_cc_pointer_register <= str_start;
            end_cc_pointer_register   <= str_end;
            state_q                   <= StStartSetup;
          end else begin
            word_ready <= 1'b1;
            state_q    <= StWrSetup;
          end
        end
        StStartSetup: begin
          cmd_register <= CmdStart;
          start_hold_q <= 1'b0;
          state_q      <= StStartCmd;
        end
        StStartCmd: begin
          if (!start_hold_q) begin
            start_hold_q <= 1'b1;
          end else begin
            cmd_register <= CmdNop;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (status_register == StatusAccepted) begin
            res_accepted <= 1'b1;
            cmd_register <= CmdReadElapsed;
            state_q      <= StElapCmd;
          end else if (status_register == StatusRejected) begin
            res_accepted <= 1'b0;
            cmd_register <= CmdReadElapsed;
            state_q      <= StElapCmd;
          end else if (status_register != StatusRunning) begin
            res_error    <= 1'b1;
            cmd_register <= CmdReadElapsed;
            state_q      <= StElapCmd;
          end
        end
        StElapCmd: begin
          cmd_register <= CmdNop;
          state_q      <= StElapCap;
        end
        StElapCap: begin
          res_cycles <= 32'(data_o_register);
          res_valid  <= 1'b1;
          state_q    <= StResult;
        end
        StResult: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            job_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cicero_job_loader.sv
// Two loaders (CC_ID_BITS = 2 and 3) share one stimulus stream; a behavioural model
// derives the expected write addresses, pointer window and result for each.
module tb_cicero_job_loader;

  localparam int CMD_NOP = 0, CMD_WRITE = 1, CMD_START = 3, CMD_ELAP = 6;
  localparam int ST_IDLE = 0, ST_RUNNING = 1, ST_ACC = 2, ST_REJ = 3, ST_ERR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, word_valid, res_ready;
  logic [15:0] job_code_words, job_string_bytes;
  logic [31:0] word_data, status_register, data_o_register;

  logic        job_ready_r [2];
  logic        word_ready_r[2];
  logic [31:0] addr_r      [2];
  logic [31:0] din_r       [2];
  logic [31:0] cmd_r       [2];
  logic [31:0] sp_r        [2];
  logic [31:0] ep_r        [2];
  logic        res_valid_r [2];
  logic        res_acc_r   [2];
  logic        res_err_r   [2];
  logic [31:0] res_cyc_r   [2];
  logic        busy_r      [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cicero_job_loader #(.CC_ID_BITS(g + 2), .REG_WIDTH(32)) u_dut (
      .clk                      (clk),
      .rst                      (rst),
      .job_valid                (job_valid),
      .job_ready                (job_ready_r[g]),
      .job_code_words           (job_code_words),
      .job_string_bytes         (job_string_bytes),
      .word_valid               (word_valid),
      .word_ready               (word_ready_r[g]),
      .word_data                (word_data),
      .address_register         (addr_r[g]),
      .data_in_register         (din_r[g]),
      .cmd_register             (cmd_r[g]),
      .start_cc_pointer_register(sp_r[g]),
      .end_cc_pointer_register  (ep_r[g]),
      .status_register          (status_register),
      .data_o_register          (data_o_register),
      .res_valid                (res_valid_r[g]),
      .res_ready                (res_ready),
      .res_accepted             (res_acc_r[g]),
      .res_error                (res_err_r[g]),
      .res_cycles               (res_cyc_r[g]),
      .busy                     (busy_r[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: aligned string start and per-word addresses.
  function automatic int unsigned ref_start(input int unsigned code, input int unsigned k);
    int unsigned a;
    a = 1 << k;
    return ((4 * code + a - 1) / a) * a;
  endfunction

  function automatic int unsigned ref_addr(input int unsigned i, input int unsigned code,
                                           input int unsigned k);
    if (i < code) return i;
    return ref_start(code, k) / 4 + (i - code);
  endfunction

  // Monitor, sampled 1 time unit after the falling edge so inputs for the next rising
  // edge and outputs from the previous one are both settled.
  logic        mon_clr = 1'b0;
  logic [31:0] wa0[$], wa1[$], wd[$];
  int          start_len, start_runs, start_max, elap_cnt, nonnop, consumed, lock_diff;
  logic [31:0] sp0, ep0, sp1, ep1;

  always @(negedge clk) begin
    #1;
    if (mon_clr) begin
      wa0.delete(); wa1.delete(); wd.delete();
      start_len = 0; start_runs = 0; start_max = 0; elap_cnt = 0;
      nonnop = 0; consumed = 0; lock_diff = 0;
    end else begin
      if (cmd_r[0] == CMD_WRITE) begin
        wa0.push_back(addr_r[0]); wa1.push_back(addr_r[1]); wd.push_back(din_r[0]);
      end
      if (cmd_r[0] == CMD_START) begin
        if (start_len == 0) start_runs++;
        start_len++;
        if (start_len > start_max) start_max = start_len;
        sp0 = sp_r[0]; ep0 = ep_r[0]; sp1 = sp_r[1]; ep1 = ep_r[1];
      end else begin
        start_len = 0;
      end
      if (cmd_r[0] == CMD_ELAP) elap_cnt++;
      if (cmd_r[0] != CMD_NOP) nonnop++;
      if (word_valid && word_ready_r[0]) consumed++;
      if ({job_ready_r[0], word_ready_r[0], cmd_r[0], din_r[0], res_valid_r[0], res_acc_r[0],
           res_err_r[0], res_cyc_r[0], busy_r[0]} !==
          {job_ready_r[1], word_ready_r[1], cmd_r[1], din_r[1], res_valid_r[1], res_acc_r[1],
           res_err_r[1], res_cyc_r[1], busy_r[1]}) lock_diff++;
    end
  end

  task automatic mon_clear();
    mon_clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic job_handshake(input int code, input int bytes);
    int t;
    job_valid = 1'b1; job_code_words = 16'(code); job_string_bytes = 16'(bytes);
    t = 0;
    while (!job_ready_r[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("job_ready_wait", job_ready_r[0], 1);
    @(negedge clk);
    job_valid = 1'b0;
    job_code_words = 16'($urandom); job_string_bytes = 16'($urandom);
  endtask

  task automatic run_job(input int code, input int bytes, input int stall_at,
                         input int wait_cycles, input int final_st, input logic [31:0] cyc,
                         input int hold_low, input bit abort_in_wait);
    logic [31:0] words[$];
    int          nwords, t;
    bit          exp_acc, exp_err;
    nwords = code + (bytes + 3) / 4;
    for (int i = 0; i < nwords; i++) words.push_back($urandom);
    status_register = ST_RUNNING; data_o_register = cyc; res_ready = 1'b0; word_valid = 1'b0;
    mon_clear();
    job_handshake(code, bytes);

    for (int i = 0; i < nwords; i++) begin
      if (i == stall_at) begin
        word_valid = 1'b0;
        t = 0;
        while (!word_ready_r[0] && t < 50) begin
          @(negedge clk);
          t++;
        end
        for (int s = 0; s < 10; s++) begin
          check_eq("stall_cmd", cmd_r[0], CMD_NOP);
          check_eq("stall_wready", word_ready_r[0], 1);
          @(negedge clk);
        end
      end
      word_valid = 1'b1; word_data = words[i];
      t = 0;
      while (!word_ready_r[0] && t < 50) begin
        @(negedge clk);
        t++;
      end
      check_eq("word_ready_wait", word_ready_r[0], 1);
      @(negedge clk);
    end
    // Keep offering junk so any over-consumption is visible.
    word_valid = 1'b1; word_data = $urandom;

    t = 0;
    while (!(start_runs >= 1 && cmd_r[0] != CMD_START) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq("reach_wait", start_runs >= 1, 1);

    if (abort_in_wait) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_cmd", cmd_r[0], CMD_NOP);
      check_eq("abort_res_valid", res_valid_r[0], 0);
      check_eq("abort_busy", busy_r[0], 0);
      check_eq("abort_wready", word_ready_r[0], 0);
      mon_clear();
      repeat (8) @(negedge clk);
      check_eq("abort_job_ready", job_ready_r[0], 1);
      check_eq("abort_consumed", consumed, 0);
      check_eq("abort_no_result", res_valid_r[0] | res_valid_r[1], 0);
      check_eq("abort_no_cmd", nonnop, 0);
      word_valid = 1'b0;
      return;
    end

    repeat (wait_cycles) @(negedge clk);
    check_eq("wait_no_result", res_valid_r[0], 0);
    check_eq("wait_cmd_nop", cmd_r[0], CMD_NOP);
    status_register = final_st;
    @(negedge clk);
    status_register = ST_RUNNING;
    t = 0;
    while (!res_valid_r[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    exp_acc = (final_st == ST_ACC);
    exp_err = !(final_st == ST_ACC || final_st == ST_REJ);
    for (int h = 0; h <= hold_low; h++) begin
      check_eq("res_valid", res_valid_r[0], 1);
      check_eq("res_error", res_err_r[0], exp_err);
      if (!exp_err) check_eq("res_accepted", res_acc_r[0], exp_acc);
      check_eq("res_cycles", res_cyc_r[0], cyc);
      if (h < hold_low) @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("res_drop", res_valid_r[0], 0);
    check_eq("idle_busy", busy_r[0], 0);
    check_eq("idle_job_ready", job_ready_r[0], 1);

    check_eq("wr_count", wd.size(), nwords);
    for (int i = 0; i < nwords && i < wd.size(); i++) begin
      check_eq("wr_addr_k2", wa0[i], ref_addr(i, code, 2));
      check_eq("wr_addr_k3", wa1[i], ref_addr(i, code, 3));
      check_eq("wr_data", wd[i], words[i]);
    end
    check_eq("start_runs", start_runs, 1);
    check_eq("start_len", start_max, 2);
    check_eq("elap_cnt", elap_cnt, 1);
    check_eq("start_ptr_k2", sp0, ref_start(code, 2));
    check_eq("end_ptr_k2", ep0, ref_start(code, 2) + bytes - 1);
    check_eq("start_ptr_k3", sp1, ref_start(code, 3));
    check_eq("end_ptr_k3", ep1, ref_start(code, 3) + bytes - 1);
    check_eq("consumed", consumed, nwords);
    check_eq("lockstep", lock_diff, 0);
    word_valid = 1'b0;
  endtask

  initial begin
    int st_pick[4];
    rst = 1'b1; job_valid = 1'b0; word_valid = 1'b0; res_ready = 1'b0;
    job_code_words = '0; job_string_bytes = '0; word_data = '0;
    status_register = ST_IDLE; data_o_register = '0;
    st_pick[0] = ST_ACC; st_pick[1] = ST_REJ; st_pick[2] = ST_ERR; st_pick[3] = ST_IDLE;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd", cmd_r[0], CMD_NOP);
    check_eq("rst_res_valid", res_valid_r[0], 0);
    check_eq("rst_busy", busy_r[0], 0);
    check_eq("rst_wready", word_ready_r[0], 0);
    check_eq("rst_regs", {addr_r[0], din_r[0], sp_r[0], ep_r[0]}, 0);
    check_eq("rst_res", {res_acc_r[0], res_err_r[0], res_cyc_r[0]}, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_job_ready", job_ready_r[0], 1);

    // code=3, bytes=5: addresses 0..4 (k=2), start 12, end 16.
    run_job(3, 5, -1, 0, ST_ACC, 32'h55, 0, 1'b0);
    check_eq("d025_last_addr", wa0[4], 4);
    check_eq("d025_start", sp0, 12);
    check_eq("d025_end", ep0, 16);
    // code=3, bytes=4 with k=3: S=16, string word at address 4, end 19.
    run_job(3, 4, -1, 0, ST_REJ, 32'h9, 0, 1'b0);
    check_eq("d026_str_addr", wa1[3], 4);
    check_eq("d026_start", sp1, 16);
    check_eq("d026_end", ep1, 19);
    // Mid-stream stall of 10 cycles.
    run_job(3, 9, 3, 2, ST_ACC, 32'h77, 0, 1'b0);
    // Long RUNNING, then accepted, result held for 5 cycles.
    run_job(2, 6, -1, 50, ST_ACC, 32'h1234, 5, 1'b0);

    // Zero-length string.
    status_register = ST_RUNNING; word_valid = 1'b1; word_data = $urandom;
    mon_clear();
    job_handshake(2, 0);
    repeat (3) @(negedge clk);
    check_eq("zero_res_valid", res_valid_r[0], 1);
    check_eq("zero_res_error", res_err_r[0], 1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0; word_valid = 1'b0;
    check_eq("zero_drop", res_valid_r[0], 0);
    check_eq("zero_no_cmd", nonnop, 0);
    check_eq("zero_consumed", consumed, 0);

    // Reset while waiting on the coprocessor, then a clean job afterwards.
    run_job(2, 3, -1, 0, ST_ACC, 32'h0, 0, 1'b1);
    run_job(1, 7, -1, 1, ST_ACC, 32'hbeef, 1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_job(int'($urandom_range(0, 6)), int'($urandom_range(1, 20)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1,
              int'($urandom_range(0, 5)), st_pick[$urandom_range(0, 3)], $urandom,
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
